// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared funct3 codes, FSM encoding and helpers for the
//               byte-serial memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam int c_funct3_width = 3;

  localparam logic [c_funct3_width-1:0] c_f3_lb  = 3'd0;
  localparam logic [c_funct3_width-1:0] c_f3_lh  = 3'd1;
  localparam logic [c_funct3_width-1:0] c_f3_lw  = 3'd2;
  localparam logic [c_funct3_width-1:0] c_f3_lbu = 3'd4;
  localparam logic [c_funct3_width-1:0] c_f3_lhu = 3'd5;

  localparam logic [c_funct3_width-1:0] c_f3_sb  = 3'd0;
  localparam logic [c_funct3_width-1:0] c_f3_sh  = 3'd1;

  // Address bits [17:16] == 2'b11 select the IO page (UART).
  localparam logic [1:0] c_io_page = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  function automatic logic is_io_page(input logic [1:0] page);
    return page == c_io_page;
  endfunction

  function automatic logic [2:0] ld_len(input logic [c_funct3_width-1:0] f3);
    case (f3)
      c_f3_lb, c_f3_lbu: return 3'd1;
      c_f3_lh, c_f3_lhu: return 3'd2;
      default:           return 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] st_len(input logic [c_funct3_width-1:0] f3);
    case (f3)
      c_f3_sb: return 3'd1;
      c_f3_sh: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_ext
// Description : Merges the byte arriving this cycle into the read buffer and
//               sign/zero-extends the result according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_ext
  import mem_arbiter_pkg::*;
#(
  parameter int VAL_WIDTH = 32
) (
  input  logic [31:0]               cur_word,
  input  logic [7:0]                new_byte,
  input  logic [1:0]                new_lane,
  input  logic [c_funct3_width-1:0] funct3,
  output logic [31:0]               word,
  output logic [VAL_WIDTH-1:0]      ext
);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign word[8*k +: 8] = (new_lane == 2'(k)) ? new_byte : cur_word[8*k +: 8];
  end

  always_comb begin
    ext = VAL_WIDTH'(word);
    case (funct3)
      c_f3_lb:  ext = VAL_WIDTH'($signed(word[7:0]));
      c_f3_lh:  ext = VAL_WIDTH'($signed(word[15:0]));
      c_f3_lbu: ext = VAL_WIDTH'(word[7:0]);
      c_f3_lhu: ext = VAL_WIDTH'(word[15:0]);
      default:  ext = VAL_WIDTH'(word);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates fetch/load/store onto the byte-wide RAM/IO port,
//               serialising words into byte cycles with registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int VAL_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush,
  input  logic                      io_buffer_full,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [ADDR_WIDTH-1:0]     mem_a,
  output logic                      mem_wr,
  input  logic                      if_req,
  input  logic [ADDR_WIDTH-1:0]     if_addr,
  output logic                      if_done,
  output logic [VAL_WIDTH-1:0]      if_data,
  input  logic                      ld_req,
  input  logic [ADDR_WIDTH-1:0]     ld_addr,
  input  logic [c_funct3_width-1:0] ld_type,
  output logic                      ld_done,
  output logic [VAL_WIDTH-1:0]      ld_data,
  input  logic                      st_req,
  input  logic [ADDR_WIDTH-1:0]     st_addr,
  input  logic [c_funct3_width-1:0] st_type,
  input  logic [VAL_WIDTH-1:0]      st_data,
  output logic                      st_done
);

  state_t                    r_state, w_state_nxt;
  logic [2:0]                r_cnt, w_cnt_nxt;
  logic [2:0]                r_len, w_len_nxt;
  logic [c_funct3_width-1:0] r_type, w_type_nxt;
  logic                      r_is_if, w_is_if_nxt;
  logic [ADDR_WIDTH-1:0]     r_mem_a, w_mem_a_nxt;
  logic [7:0]                r_mem_dout, w_mem_dout_nxt;
  logic                      r_mem_wr, w_mem_wr_nxt;
  logic [31:0]               r_buf, w_buf_nxt;
  logic [VAL_WIDTH-1:0]      r_wdata, w_wdata_nxt;
  logic                      r_if_done, w_if_done_nxt;
  logic                      r_ld_done, w_ld_done_nxt;
  logic                      r_st_done, w_st_done_nxt;
  logic [VAL_WIDTH-1:0]      r_if_data, w_if_data_nxt;
  logic [VAL_WIDTH-1:0]      r_ld_data, w_ld_data_nxt;

  logic                      w_st_elig, w_ld_elig, w_if_elig, w_st_blocked;
  logic [1:0]                w_cap_lane;
  logic [31:0]               w_word;
  logic [VAL_WIDTH-1:0]      w_ext;

  // A requester still seeing its done pulse must not be re-granted.
  assign w_st_elig    = st_req && !r_st_done;
  assign w_ld_elig    = ld_req && !r_ld_done;
  assign w_if_elig    = if_req && !r_if_done;
  assign w_st_blocked = is_io_page(st_addr[17:16]) && io_buffer_full;

  // RAM data lags the address by two edges, so step s captures lane s-2.
  assign w_cap_lane = r_cnt[1:0] - 2'd2;

  mem_load_ext #(
    .VAL_WIDTH (VAL_WIDTH)
  ) u_load_ext (
    .cur_word (r_buf),
    .new_byte (mem_din),
    .new_lane (w_cap_lane),
    .funct3   (r_type),
    .word     (w_word),
    .ext      (w_ext)
  );

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_len      <= 3'd0;
      r_type     <= '0;
      r_is_if    <= 1'b0;
      r_mem_a    <= '0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_buf      <= 32'd0;
      r_wdata    <= '0;
      r_if_done  <= 1'b0;
      r_ld_done  <= 1'b0;
      r_st_done  <= 1'b0;
      r_if_data  <= '0;
      r_ld_data  <= '0;
    end else if (rdy_in) begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_len      <= w_len_nxt;
      r_type     <= w_type_nxt;
      r_is_if    <= w_is_if_nxt;
      r_mem_a    <= w_mem_a_nxt;
      r_mem_dout <= w_mem_dout_nxt;
      r_mem_wr   <= w_mem_wr_nxt;
      r_buf      <= w_buf_nxt;
      r_wdata    <= w_wdata_nxt;
      r_if_done  <= w_if_done_nxt;
      r_ld_done  <= w_ld_done_nxt;
      r_st_done  <= w_st_done_nxt;
      r_if_data  <= w_if_data_nxt;
      r_ld_data  <= w_ld_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_len_nxt      = r_len;
    w_type_nxt     = r_type;
    w_is_if_nxt    = r_is_if;
    w_mem_a_nxt    = r_mem_a;
    w_mem_dout_nxt = r_mem_dout;
    w_mem_wr_nxt   = r_mem_wr;
    w_buf_nxt      = r_buf;
    w_wdata_nxt    = r_wdata;
    w_if_done_nxt  = 1'b0;
    w_ld_done_nxt  = 1'b0;
    w_st_done_nxt  = 1'b0;
    w_if_data_nxt  = r_if_data;
    w_ld_data_nxt  = r_ld_data;

    case (r_state)
      ST_IDLE: begin
        // A pending store holds off loads and fetches even while blocked.
        if (w_st_elig) begin
          if (!w_st_blocked) begin
            w_state_nxt    = ST_WR;
            w_cnt_nxt      = 3'd1;
            w_len_nxt      = st_len(st_type);
            w_mem_a_nxt    = st_addr;
            w_mem_dout_nxt = st_data[7:0];
            w_mem_wr_nxt   = 1'b1;
            w_wdata_nxt    = st_data;
          end
        end else if (!flush && w_ld_elig) begin
          w_state_nxt  = ST_RD;
          w_cnt_nxt    = 3'd1;
          w_len_nxt    = ld_len(ld_type);
          w_type_nxt   = ld_type;
          w_is_if_nxt  = 1'b0;
          w_mem_a_nxt  = ld_addr;
          w_mem_wr_nxt = 1'b0;
          w_buf_nxt    = 32'd0;
        end else if (!flush && w_if_elig) begin
          w_state_nxt  = ST_RD;
          w_cnt_nxt    = 3'd1;
          w_len_nxt    = 3'd4;
          w_type_nxt   = c_f3_lw;
          w_is_if_nxt  = 1'b1;
          w_mem_a_nxt  = if_addr;
          w_mem_wr_nxt = 1'b0;
          w_buf_nxt    = 32'd0;
        end
      end

      ST_RD: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 3'd0;
          w_mem_a_nxt = '0;
        end else begin
          if (r_cnt < r_len) begin
            w_mem_a_nxt = r_mem_a + ADDR_WIDTH'(1);
          end
          if (r_cnt >= 3'd2) begin
            w_buf_nxt = w_word;
          end
          if (r_cnt == r_len + 3'd1) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
            if (r_is_if) begin
              w_if_done_nxt = 1'b1;
              w_if_data_nxt = VAL_WIDTH'(w_word);
            end else begin
              w_ld_done_nxt = 1'b1;
              w_ld_data_nxt = w_ext;
            end
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end

      ST_WR: begin
        if (r_cnt < r_len) begin
          w_mem_a_nxt    = r_mem_a + ADDR_WIDTH'(1);
          w_mem_dout_nxt = r_wdata[8*r_cnt[1:0] +: 8];
          w_cnt_nxt      = r_cnt + 3'd1;
        end else begin
          w_mem_wr_nxt  = 1'b0;
          w_st_done_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = 3'd0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign mem_a    = r_mem_a;
  assign mem_dout = r_mem_dout;
  assign mem_wr   = r_mem_wr;
  assign if_done  = r_if_done;
  assign if_data  = r_if_data;
  assign ld_done  = r_ld_done;
  assign ld_data  = r_ld_data;
  assign st_done  = r_st_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a byte RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush, io_buffer_full;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ld_req, ld_done;
  logic [31:0] ld_addr, ld_data;
  logic [2:0]  ld_type;
  logic        st_req, st_done;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_type;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH (32),
    .VAL_WIDTH  (32)
  ) dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush          (flush),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .ld_req         (ld_req),
    .ld_addr        (ld_addr),
    .ld_type        (ld_type),
    .ld_done        (ld_done),
    .ld_data        (ld_data),
    .st_req         (st_req),
    .st_addr        (st_addr),
    .st_type        (st_type),
    .st_data        (st_data),
    .st_done        (st_done)
  );

  // Synchronous byte RAM; it holds along with the core while rdy_in is low.
  logic [7:0]  ram [0:262143];
  logic [31:0] wlog_a [$];
  logic [7:0]  wlog_d [$];

  always @(posedge clk) begin
    if (rdy_in) begin
      if (mem_wr) begin
        ram[mem_a[17:0]] <= mem_dout;
        wlog_a.push_back(mem_a);
        wlog_d.push_back(mem_dout);
      end
      mem_din <= ram[mem_a[17:0]];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  int cyc, wr_cycles;
  int st_cnt, ld_cnt, if_cnt;
  int st_at, ld_at, if_at;
  int st_drop, ld_drop, if_drop;

  task automatic mon_reset();
    cyc = 0; wr_cycles = 0;
    st_cnt = 0; ld_cnt = 0; if_cnt = 0;
    st_at = -1; ld_at = -1; if_at = -1;
    st_drop = -1; ld_drop = -1; if_drop = -1;
    wlog_a.delete();
    wlog_d.delete();
  endtask

  // Requesters drop their request one cycle after seeing done, like a
  // registered client would.
  task automatic monitor(input int ncyc);
    repeat (ncyc) begin
      @(negedge clk);
      if (cyc == st_drop) st_req = 1'b0;
      if (cyc == ld_drop) ld_req = 1'b0;
      if (cyc == if_drop) if_req = 1'b0;
      if (mem_wr) wr_cycles++;
      if (st_done) begin st_cnt++; st_at = cyc; st_drop = cyc + 1; end
      if (ld_done) begin ld_cnt++; ld_at = cyc; ld_drop = cyc + 1; end
      if (if_done) begin if_cnt++; if_at = cyc; if_drop = cyc + 1; end
      cyc++;
    end
  endtask

  task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] exp, input int exp_lat);
    int lat;
    int last;
    lat  = -1;
    last = exp_lat - 2;
    @(negedge clk);
    ld_addr = a; ld_type = t; ld_req = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check_eq({tag, ".addr"}, mem_a, a + 32'((n < last) ? n : last));
      if (ld_done) begin
        lat = n;
        break;
      end
    end
    ld_req = 1'b0;
    check_eq({tag, ".lat"}, lat, exp_lat);
    check_eq({tag, ".data"}, ld_data, exp);
  endtask

  logic [7:0] sw_bytes [4];

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ld_req = 1'b0; ld_addr = '0; ld_type = '0;
    st_req = 1'b0; st_addr = '0; st_type = '0; st_data = '0;
    sw_bytes[0] = 8'hEF; sw_bytes[1] = 8'hBE; sw_bytes[2] = 8'hAD; sw_bytes[3] = 8'hDE;

    ram[18'h00100] = 8'h78; ram[18'h00101] = 8'h56;
    ram[18'h00102] = 8'h34; ram[18'h00103] = 8'h12;
    ram[18'h00080] = 8'h80;
    ram[18'h00180] = 8'h00; ram[18'h00181] = 8'h80;
    ram[18'h00182] = 8'hCD; ram[18'h00183] = 8'hAB;
    ram[18'h00300] = 8'h13; ram[18'h00301] = 8'h00;
    ram[18'h00302] = 8'h00; ram[18'h00303] = 8'h00;

    repeat (3) @(negedge clk);
    check_eq("rst.mem_a", mem_a, 32'h0);
    check_eq("rst.mem_dout", {24'h0, mem_dout}, 32'h0);
    check_eq("rst.mem_wr", {31'h0, mem_wr}, 32'h0);
    check_eq("rst.dones", {29'h0, if_done, ld_done, st_done}, 32'h0);
    check_eq("rst.if_data", if_data, 32'h0);
    check_eq("rst.ld_data", ld_data, 32'h0);
    rst_in = 1'b0;

    run_load("lw",  32'h100, 3'd2, 32'h12345678, 5);
    run_load("lb",  32'h080, 3'd0, 32'hFFFFFF80, 2);
    run_load("lbu", 32'h080, 3'd4, 32'h00000080, 2);
    run_load("lh",  32'h180, 3'd1, 32'hFFFF8000, 3);
    run_load("lhu", 32'h180, 3'd5, 32'h00008000, 3);

    // All three requesters at once: store, then load, then fetch.
    @(negedge clk);
    st_addr = 32'h200; st_type = 3'd2; st_data = 32'hDEADBEEF; st_req = 1'b1;
    ld_addr = 32'h100; ld_type = 3'd2; ld_req = 1'b1;
    if_addr = 32'h300; if_req = 1'b1;
    mon_reset();
    monitor(24);
    check_eq("prio.st_at", st_at, 4);
    check_eq("prio.ld_at", ld_at, 10);
    check_eq("prio.if_at", if_at, 16);
    check_eq("prio.counts", {st_cnt[7:0], ld_cnt[7:0], if_cnt[7:0]}, 32'h010101);
    check_eq("prio.nwr", wlog_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wlog_a.size()) begin
        check_eq($sformatf("prio.wa%0d", i), wlog_a[i], 32'h200 + 32'(i));
        check_eq($sformatf("prio.wd%0d", i), {24'h0, wlog_d[i]}, {24'h0, sw_bytes[i]});
      end
    end
    check_eq("prio.ld_data", ld_data, 32'h12345678);
    check_eq("prio.if_data", if_data, 32'h00000013);

    // IO store held off by a full UART buffer; the fetch must wait too.
    io_buffer_full = 1'b1;
    st_addr = 32'h30000; st_type = 3'd0; st_data = 32'h00000041; st_req = 1'b1;
    if_addr = 32'h300; if_req = 1'b1;
    mon_reset();
    monitor(3);
    check_eq("io.blk_wr", wr_cycles, 0);
    check_eq("io.blk_done", {st_cnt[15:0], if_cnt[15:0]}, 32'h0);
    check_eq("io.blk_mem_a", mem_a, 32'h303);
    io_buffer_full = 1'b0;
    monitor(12);
    check_eq("io.st_cnt", st_cnt, 1);
    check_eq("io.st_at", st_at, 4);
    check_eq("io.wr_cycles", wr_cycles, 1);
    check_eq("io.nwr", wlog_a.size(), 1);
    if (wlog_a.size() > 0) begin
      check_eq("io.wa", wlog_a[0], 32'h30000);
      check_eq("io.wd", {24'h0, wlog_d[0]}, 32'h41);
    end
    check_eq("io.if_at", if_at, 10);
    check_eq("io.if_data", if_data, 32'h00000013);

    // Flush two edges into a fetch, held for the idle edge as well.
    if_addr = 32'h100; if_req = 1'b1;
    mon_reset();
    monitor(2);
    flush = 1'b1;
    monitor(1);
    check_eq("fl.abort_mem_a", mem_a, 32'h0);
    check_eq("fl.abort_wr", {31'h0, mem_wr}, 32'h0);
    monitor(1);
    check_eq("fl.idle_mem_a", mem_a, 32'h0);
    check_eq("fl.no_done", if_cnt, 0);
    flush = 1'b0;
    monitor(10);
    check_eq("fl.if_cnt", if_cnt, 1);
    check_eq("fl.if_at", if_at, 9);
    check_eq("fl.if_data", if_data, 32'h12345678);

    // Four frozen cycles in the middle of a word load.
    ld_addr = 32'h180; ld_type = 3'd2; ld_req = 1'b1;
    mon_reset();
    monitor(2);
    rdy_in = 1'b0;
    monitor(2);
    check_eq("rdy.frozen_mem_a", mem_a, 32'h181);
    monitor(2);
    rdy_in = 1'b1;
    monitor(6);
    check_eq("rdy.ld_cnt", ld_cnt, 1);
    check_eq("rdy.ld_at", ld_at, 9);
    check_eq("rdy.ld_data", ld_data, 32'hABCD8000);

    // Asynchronous reset in the middle of a word store.
    st_addr = 32'h210; st_type = 3'd2; st_data = 32'hCAFEF00D; st_req = 1'b1;
    mon_reset();
    monitor(2);
    check_eq("rst2.pre_wr", {31'h0, mem_wr}, 32'h1);
    rst_in = 1'b1;
    #1;
    check_eq("rst2.mem_a", mem_a, 32'h0);
    check_eq("rst2.mem_dout", {24'h0, mem_dout}, 32'h0);
    check_eq("rst2.mem_wr", {31'h0, mem_wr}, 32'h0);
    check_eq("rst2.dones", {29'h0, if_done, ld_done, st_done}, 32'h0);
    check_eq("rst2.ld_data", ld_data, 32'h0);
    check_eq("rst2.if_data", if_data, 32'h0);
    st_req = 1'b0;
    @(negedge clk);
    rst_in = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst2.after_wr", {31'h0, mem_wr}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
